// File: rtl/dual_port_mem_responder.sv
//==============================================================================
// Module   : dual_port_mem_responder
// Brief    : Shared 16-bit word memory serving split inst/data CPU ports, one
//            transaction at a time with fixed latency. Define MEM_RR_ARB_EN
//            for round-robin arbitration (default: data over inst priority).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module dual_port_mem_responder #(
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inst_mem_read,
    input  logic        inst_mem_write,
    input  logic [1:0]  inst_mem_byte_enable,
    input  logic [15:0] inst_mem_addr,
    input  logic [15:0] inst_mem_wdata,
    output logic [15:0] inst_mem_rdata,
    output logic        inst_mem_resp,
    input  logic        data_mem_read,
    input  logic        data_mem_write,
    input  logic [1:0]  data_mem_byte_enable,
    input  logic [15:0] data_mem_addr,
    input  logic [15:0] data_mem_wdata,
    output logic [15:0] data_mem_rdata,
    output logic        data_mem_resp
);

    localparam int         DEPTH       = 2 ** ADDR_BITS;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_BUSY      = 2'd1;
    localparam logic [1:0] S_RESP      = 2'd2;
    localparam logic [3:0] C_CNT_LOAD  = 4'(LATENCY - 1);
    localparam bit         C_SINGLE    = (LATENCY == 1);
    localparam logic       C_PORT_INST = 1'b0;
    localparam logic       C_PORT_DATA = 1'b1;

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 port_q, port_d;
    logic                 wr_q, wr_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d;
    logic [15:0]          wdata_q, wdata_d;
    logic [1:0]           be_q, be_d;
    logic [15:0]          inst_rdata_q, inst_rdata_d;
    logic [15:0]          data_rdata_q, data_rdata_d;
    logic [15:0]          mem_q [DEPTH];

    logic w_inst_req;
    logic w_data_req;
    logic w_any_req;
    logic w_grant_data;
    logic w_load_rdata;
    logic w_mem_we;
    logic w_unused;

    assign w_inst_req = inst_mem_read | inst_mem_write;
    assign w_data_req = data_mem_read | data_mem_write;
    assign w_any_req  = w_inst_req | w_data_req;

    // Only addr[ADDR_BITS:1] selects a word; the remaining address bits alias.
    assign w_unused = ^{inst_mem_addr, data_mem_addr};

`ifdef MEM_RR_ARB_EN
    logic last_q, last_d;

    // On a tie, grant whichever port did not win the previous grant.
    always_comb begin
        w_grant_data = w_data_req && (!w_inst_req || (last_q == C_PORT_INST));
        last_d       = last_q;
        if ((state_q == S_IDLE) && w_any_req) begin
            last_d = w_grant_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= C_PORT_INST;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        w_grant_data = w_data_req;
    end
`endif

    // State and transaction-latch registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            port_q       <= C_PORT_INST;
            wr_q         <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 16'h0000;
            be_q         <= 2'b00;
            inst_rdata_q <= 16'h0000;
            data_rdata_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            wr_q         <= wr_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    // Next-state and request latching
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    if (w_grant_data) begin
                        port_d  = C_PORT_DATA;
                        wr_d    = data_mem_write;
                        idx_d   = data_mem_addr[ADDR_BITS:1];
                        wdata_d = data_mem_wdata;
                        be_d    = data_mem_byte_enable;
                    end else begin
                        port_d  = C_PORT_INST;
                        wr_d    = inst_mem_write;
                        idx_d   = inst_mem_addr[ADDR_BITS:1];
                        wdata_d = inst_mem_wdata;
                        be_d    = inst_mem_byte_enable;
                    end
                    if (C_SINGLE) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = C_CNT_LOAD;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // No re-grant here: the requester still shows the finished request.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read data is captured on entry to RESP so it is visible with resp.
    always_comb begin
        w_load_rdata = (state_d == S_RESP) && (state_q != S_RESP) && !wr_d;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (w_load_rdata) begin
            if (port_d == C_PORT_DATA) begin
                data_rdata_d = mem_q[idx_d];
            end else begin
                inst_rdata_d = mem_q[idx_d];
            end
        end
    end

    assign w_mem_we = (state_q == S_RESP) && wr_q;

    // Storage is not reset; an aborted transaction never reaches RESP.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            if (be_q[0]) begin
                mem_q[idx_q][7:0] <= wdata_q[7:0];
            end
            if (be_q[1]) begin
                mem_q[idx_q][15:8] <= wdata_q[15:8];
            end
        end
    end

    // Outputs
    always_comb begin
        inst_mem_resp  = (state_q == S_RESP) && (port_q == C_PORT_INST);
        data_mem_resp  = (state_q == S_RESP) && (port_q == C_PORT_DATA);
        inst_mem_rdata = inst_rdata_q;
        data_mem_rdata = data_rdata_q;
    end

endmodule

`default_nettype wire
